line_fill_responder: RTL and testbench

// - Next-level memory responder for the cache's nextlevel master port: services whole-line READ (fill) and WRITE (dirty writeback) requests.
// - Backs MEMLINES lines of storage, answers after a fixed LATENCY and moves data one word per beat.
// - Counts serviced operations for the cache statistics report.
// - Sits below the last cache level; used as main memory in simulation and as the reference model for the cache bench.

---
 rtl/line_fill_responder.sv | 212 +++++++++++++++++++++
 tb/tb_line_fill_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// Line fill responder: next-level memory below the last cache level.
// Services whole-line READ fills and WRITE writebacks after a fixed latency,
// one word per beat, and counts completed operations.
module line_fill_responder #(
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned WORDBITS  = 32,
  parameter int unsigned LINEITEMS = 16,
  parameter int unsigned MEMLINES  = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDRBITS-1:0] req_addr,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WORDBITS-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [WORDBITS-1:0] rd_data,
  output logic                rd_last,
  output logic                wr_done,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count
);

  localparam int unsigned BYTES     = WORDBITS / 8;
  localparam int unsigned LINEBYTES = LINEITEMS * BYTES;
  localparam int unsigned OFFBITS   = $clog2(LINEBYTES);
  localparam int unsigned IDXBITS   = $clog2(MEMLINES);
  localparam int unsigned BEATBITS  = $clog2(LINEITEMS);
  localparam int unsigned LATBITS   = $clog2(LATENCY + 1);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_RD_BURST = 3'd2;
  localparam logic [2:0] ST_WR_BURST = 3'd3;
  localparam logic [2:0] ST_WR_WAIT  = 3'd4;
  localparam logic [2:0] ST_WR_ACK   = 3'd5;

  localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(LINEITEMS - 1);
  localparam logic [LATBITS-1:0]  LAST_LAT  = LATBITS'(LATENCY - 1);
  localparam logic [ADDRBITS-1:0] OFF_MASK  = ADDRBITS'(LINEBYTES - 1);

  logic [2:0]          state_q, state_d;
  logic [BEATBITS-1:0] beat_q, beat_d;
  logic [LATBITS-1:0]  lat_q, lat_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [31:0]         read_count_q, read_count_d;
  logic [31:0]         write_count_q, write_count_d;
  logic [MEMLINES-1:0] line_valid_q, line_valid_d;
  logic [WORDBITS-1:0] stage_q [LINEITEMS];
  logic [WORDBITS-1:0] stage_d [LINEITEMS];

  // Backing storage is never cleared; line_valid_q decides whether it is meaningful.
  logic [WORDBITS-1:0] storage_mem [MEMLINES][LINEITEMS];

  logic                commit;
  logic [IDXBITS-1:0]  line_idx;
  logic [ADDRBITS-1:0] pattern;

  // Line index is taken from the latched request; upper bits alias freely.
  assign line_idx = addr_q[OFFBITS +: IDXBITS];

  // Unwritten lines return each word's own byte address.
  assign pattern = (addr_q & ~OFF_MASK) + ADDRBITS'(beat_q) * ADDRBITS'(BYTES);

  // Next-state logic for the request/burst sequencer.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    addr_d        = addr_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    line_valid_d  = line_valid_q;
    stage_d       = stage_q;
    commit        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // NOP and reserved ops are accepted here and dropped.
        if (req_valid) begin
          if (req_op == OP_READ) begin
            state_d = ST_RD_WAIT;
            lat_d   = '0;
            addr_d  = req_addr;
          end else if (req_op == OP_WRITE) begin
            state_d = ST_WR_BURST;
            beat_d  = '0;
            addr_d  = req_addr;
          end
        end
      end

      ST_RD_WAIT: begin
        if (lat_q == LAST_LAT) begin
          state_d = ST_RD_BURST;
          beat_d  = '0;
        end else begin
          lat_d = lat_q + LATBITS'(1);
        end
      end

      ST_RD_BURST: begin
        if (rd_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d      = ST_IDLE;
            read_count_d = read_count_q + 32'd1;
          end else begin
            beat_d = beat_q + BEATBITS'(1);
          end
        end
      end

      ST_WR_BURST: begin
        if (wr_valid) begin
          stage_d[beat_q] = wr_data;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WR_WAIT;
            lat_d   = '0;
          end else begin
            beat_d = beat_q + BEATBITS'(1);
          end
        end
      end

      ST_WR_WAIT: begin
        if (lat_q == LAST_LAT) begin
          state_d                = ST_WR_ACK;
          commit                 = 1'b1;
          line_valid_d[line_idx] = 1'b1;
          write_count_d          = write_count_q + 32'd1;
        end else begin
          lat_d = lat_q + LATBITS'(1);
        end
      end

      ST_WR_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      lat_q         <= '0;
      addr_q        <= '0;
      read_count_q  <= '0;
      write_count_q <= '0;
      line_valid_q  <= '0;
      for (int i = 0; i < LINEITEMS; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      addr_q        <= addr_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      line_valid_q  <= line_valid_d;
      stage_q       <= stage_d;
    end
  end

  // Copy the staged line into storage when the writeback commits.
  always_ff @(posedge clock) begin
    if (commit && !reset) begin
      for (int i = 0; i < LINEITEMS; i++) begin
        storage_mem[line_idx][i] <= stage_q[i];
      end
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rd_valid  = (state_q == ST_RD_BURST);
    wr_ready  = (state_q == ST_WR_BURST);
    wr_done   = (state_q == ST_WR_ACK);
    rd_last   = (state_q == ST_RD_BURST) && (beat_q == LAST_BEAT);
  end

  // Read data: stored word for written lines, address pattern otherwise.
  always_comb begin
    rd_data = '0;
    if (state_q == ST_RD_BURST) begin
      if (line_valid_q[line_idx]) begin
        rd_data = storage_mem[line_idx][beat_q];
      end else begin
        rd_data = WORDBITS'(pattern);
      end
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder with default parameters
// (32-bit words, 16-word lines, 1024 lines, latency 4).
module tb_line_fill_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_done;
  logic [31:0] read_count;
  logic [31:0] write_count;

  int checks = 0;
  int errors = 0;

  // Results of the most recent burst, filled by the stimulus tasks.
  logic [31:0] got [16];
  int          lat;
  int          beats;
  int          last_pos;
  int          hold_bad;
  int          stall_seen;
  logic [31:0] hold_val;
  int          wlat;
  int          done_width;

  // Expected counter values, advanced by the bench per operation.
  int exp_rd;
  int exp_wr;

  always #5 clock = ~clock;

  line_fill_responder dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .wr_done     (wr_done),
    .read_count  (read_count),
    .write_count (write_count)
  );

  task tick;
    @(posedge clock);
    #1;
  endtask

  // Issue a READ and collect the burst; optionally stall at one beat.
  task read_line(input logic [31:0] addr, input int stall_beat, input int stall_len);
    int  cyc;
    int  stall_left;
    bit  done;
    lat = 0; beats = 0; last_pos = -1; hold_bad = 0; stall_seen = 0;
    hold_val = '0; stall_left = stall_len; done = 0;
    for (int i = 0; i < 16; i++) got[i] = 'x;
    req_valid = 1'b1; req_op = 2'd1; req_addr = addr;
    cyc = 0;
    while (!req_ready && cyc < 20) begin tick; cyc++; end
    tick;
    req_valid = 1'b0; req_op = 2'd0;
    while (!rd_valid && lat < 50) begin tick; lat++; end
    cyc = 0;
    while (!done && cyc < 100) begin
      if (rd_valid) begin
        if (beats == stall_beat && stall_left > 0) begin
          if (stall_left == stall_len) hold_val = rd_data;
          else if (rd_data !== hold_val) hold_bad++;
          stall_left--; stall_seen++;
          rd_ready = 1'b0;
        end else begin
          if (beats == stall_beat && stall_len > 0 && rd_data !== hold_val) hold_bad++;
          rd_ready = 1'b1;
          if (beats < 16) got[beats] = rd_data;
          if (rd_last) begin last_pos = beats; done = 1; end
          beats++;
        end
      end else begin
        rd_ready = 1'b0;
      end
      tick; cyc++;
    end
    rd_ready = 1'b0;
  endtask

  // Issue a WRITE with nbeats words first+i; optional 2-cycle gap before beat gap_at.
  task write_line(input logic [31:0] addr, input logic [31:0] first, input int nbeats,
                  input int gap_at);
    int cyc;
    req_valid = 1'b1; req_op = 2'd2; req_addr = addr;
    cyc = 0;
    while (!req_ready && cyc < 20) begin tick; cyc++; end
    tick;
    req_valid = 1'b0; req_op = 2'd0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin wr_valid = 1'b0; tick; tick; end
      wr_valid = 1'b1; wr_data = first + 32'(i);
      cyc = 0;
      while (!wr_ready && cyc < 20) begin tick; cyc++; end
      tick;
    end
    wr_valid = 1'b0; wr_data = '0;
  endtask

  // Wait for the wr_done pulse and measure its width.
  task wait_done;
    wlat = 0;
    while (!wr_done && wlat < 50) begin tick; wlat++; end
    done_width = 0;
    while (wr_done && done_width < 10) begin done_width++; tick; end
  endtask

  task test_reset;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b expected 0", wr_done); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (read_count !== 32'd0) begin errors++; $display("FAIL reset_read_count: got %0d expected 0", read_count); end
    checks++; if (write_count !== 32'd0) begin errors++; $display("FAIL reset_write_count: got %0d expected 0", write_count); end
  endtask

  task test_read_pattern;
    read_line(32'h0000_1040, -1, 0);
    exp_rd++;
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", lat); end
    checks++; if (beats !== 16) begin errors++; $display("FAIL read_beats: got %0d expected 16", beats); end
    checks++; if (last_pos !== 15) begin errors++; $display("FAIL read_last_pos: got %0d expected 15", last_pos); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'h1040 + 32'(4 * i)) begin
        errors++; $display("FAIL read_pattern[%0d]: got %h expected %h", i, got[i], 32'h1040 + 32'(4 * i));
      end
    end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL read_count1: got %0d expected %0d", read_count, exp_rd); end
  endtask

  task test_write_readback;
    write_line(32'h0000_1040, 32'hA0, 16, 3);
    wait_done;
    exp_wr++;
    checks++; if (wlat !== 4) begin errors++; $display("FAIL write_done_latency: got %0d expected 4", wlat); end
    checks++; if (done_width !== 1) begin errors++; $display("FAIL write_done_width: got %0d expected 1", done_width); end
    checks++; if (write_count !== 32'(exp_wr)) begin errors++; $display("FAIL write_count1: got %0d expected %0d", write_count, exp_wr); end
    read_line(32'h0000_1040, -1, 0);
    exp_rd++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL write_readback[%0d]: got %h expected %h", i, got[i], 32'hA0 + 32'(i));
      end
    end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL read_count2: got %0d expected %0d", read_count, exp_rd); end
  endtask

  task test_backpressure;
    read_line(32'h0000_1040, 5, 3);
    exp_rd++;
    checks++; if (stall_seen !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
    checks++; if (hold_val !== 32'hA5) begin errors++; $display("FAIL bp_hold_word: got %h expected a5", hold_val); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes expected 0", hold_bad); end
    checks++; if (beats !== 16) begin errors++; $display("FAIL bp_beats: got %0d expected 16", beats); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task test_alias;
    read_line(32'h0001_1040, -1, 0);
    exp_rd++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL alias_data[%0d]: got %h expected %h", i, got[i], 32'hA0 + 32'(i));
      end
    end
    // Unaligned address into an untouched line: offset bits are ignored.
    read_line(32'h0000_2024, -1, 0);
    exp_rd++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'h2000 + 32'(4 * i)) begin
        errors++; $display("FAIL unwritten_data[%0d]: got %h expected %h", i, got[i], 32'h2000 + 32'(4 * i));
      end
    end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL read_count3: got %0d expected %0d", read_count, exp_rd); end
  endtask

  task test_nop;
    int bad;
    bad = 0;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h1040;
    tick;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL nop_stays_idle: got %b expected 1", req_ready); end
    req_op = 2'd3;
    tick;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reserved_stays_idle: got %b expected 1", req_ready); end
    req_valid = 1'b0; req_op = 2'd0;
    // Stray beats outside a burst must be ignored.
    wr_valid = 1'b1; wr_data = 32'hDEAD; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || wr_done !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL nop_no_response: got %0d bad cycles expected 0", bad); end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL nop_read_count: got %0d expected %0d", read_count, exp_rd); end
    checks++; if (write_count !== 32'(exp_wr)) begin errors++; $display("FAIL nop_write_count: got %0d expected %0d", write_count, exp_wr); end
  endtask

  task test_back_to_back;
    read_line(32'h0000_1040, -1, 0);
    exp_rd++;
    checks++; if (got[0] !== 32'hA0 || got[15] !== 32'hAF) begin
      errors++; $display("FAIL b2b_first: got %h..%h expected a0..af", got[0], got[15]);
    end
    read_line(32'h0000_4000, -1, 0);
    exp_rd++;
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (got[0] !== 32'h4000 || got[15] !== 32'h403C) begin
      errors++; $display("FAIL b2b_second: got %h..%h expected 4000..403c", got[0], got[15]);
    end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL b2b_read_count: got %0d expected %0d", read_count, exp_rd); end
  endtask

  task test_reset_midwrite;
    int seen;
    write_line(32'h0000_3000, 32'h55, 7, -1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready: got %b expected 1", req_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_ready: got %b expected 0", wr_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_done) seen++;
      tick;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", seen); end
    checks++; if (write_count !== 32'd0) begin errors++; $display("FAIL rst_mid_write_count: got %0d expected 0", write_count); end
    read_line(32'h0000_3000, -1, 0);
    exp_rd++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'h3000 + 32'(4 * i)) begin
        errors++; $display("FAIL rst_mid_data[%0d]: got %h expected %h", i, got[i], 32'h3000 + 32'(4 * i));
      end
    end
    // Reset also cleared the valid bit of the line written earlier.
    read_line(32'h0000_1040, -1, 0);
    exp_rd++;
    checks++; if (got[0] !== 32'h1040 || got[15] !== 32'h107C) begin
      errors++; $display("FAIL rst_valid_cleared: got %h..%h expected 1040..107c", got[0], got[15]);
    end
    checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL rst_read_count: got %0d expected %0d", read_count, exp_rd); end
  endtask

  initial begin
    test_reset;
    test_read_pattern;
    test_write_readback;
    test_backpressure;
    test_alias;
    test_nop;
    test_back_to_back;
    test_reset_midwrite;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
